// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants, widths and total helpers
//   (package, no ports)
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int RGB_W = 8;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = 10;

  function automatic int h_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  function automatic int v_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - framebuffer read bus between scanout and video memory
//   fb_read_en  master->slave  pixel read request, one pixel period
//   fb_x        master->slave  requested column
//   fb_y        master->slave  requested row
//   fb_rgb      slave->master  {r,g,b} returned FB_LATENCY pixel periods later
interface vga_scanout_if;
  import vga_timing_pkg::*;

  logic                 fb_read_en;
  logic [X_W-1:0]       fb_x;
  logic [Y_W-1:0]       fb_y;
  logic [3*RGB_W-1:0]   fb_rgb;

  modport master (output fb_read_en, output fb_x, output fb_y, input fb_rgb);
  modport slave  (input fb_read_en, input fb_x, input fb_y, output fb_rgb);

endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with synchronous active-low clear
//   clk      in   clock
//   clear_n  in   synchronous clear, active-low; every stage goes to 0
//   en       in   advance the line by one stage
//   din      in   WIDTH bits into stage 0
//   dout     out  WIDTH bits out of stage DEPTH-1
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (en) begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator, framebuffer requester and pin alignment
//   clk              in   50 MHz system clock
//   reset_n          in   synchronous reset, active-low
//   fb               master framebuffer read bus (fb_read_en, fb_x, fb_y / fb_rgb)
//   vga_r/g/b        out  colour, 0 outside the visible area
//   vga_hsync/vsync  out  active-low syncs
//   vga_blank        out  1 outside the visible area
//   vga_pixel_clock  out  clk/2
//   frame_start      out  one-clk pulse when pixel (0,0) reaches the pins
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int FB_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_scanout_if.master      fb,
  output logic [RGB_W-1:0]   vga_r,
  output logic [RGB_W-1:0]   vga_g,
  output logic [RGB_W-1:0]   vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_blank,
  output logic               vga_pixel_clock,
  output logic               frame_start
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic             phase;
  logic             pixel_edge;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             visible, hs, vs, first_pixel;
  logic             visible_d, hs_d, vs_d, first_d;

  // The edge on which phase falls 1->0 is the only one that moves anything,
  // so the pins settle half a pixel before each vga_pixel_clock rise.
  assign pixel_edge      = phase;
  assign vga_pixel_clock = phase;

  always_comb begin
    visible     = (h_count < H_VIS) && (v_count < V_VIS);
    hs          = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
    vs          = (v_count >= VS_FIRST) && (v_count <= VS_LAST);
    first_pixel = (h_count == '0) && (v_count == '0);
  end

  // Carries the timing bits alongside the in-flight read so they meet the
  // returned colour at the pin register.
  vga_delay_line #(
    .WIDTH (4),
    .DEPTH (FB_LATENCY)
  ) u_align (
    .clk     (clk),
    .clear_n (reset_n),
    .en      (pixel_edge),
    .din     ({visible, hs, vs, first_pixel}),
    .dout    ({visible_d, hs_d, vs_d, first_d})
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase         <= 1'b0;
      h_count       <= '0;
      v_count       <= '0;
      fb.fb_read_en <= 1'b0;
      fb.fb_x       <= '0;
      fb.fb_y       <= '0;
      vga_r         <= '0;
      vga_g         <= '0;
      vga_b         <= '0;
      vga_hsync     <= 1'b1;
      vga_vsync     <= 1'b1;
      vga_blank     <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      phase       <= ~phase;
      frame_start <= 1'b0;
      if (pixel_edge) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end

        fb.fb_read_en <= visible;
        if (visible) begin
          fb.fb_x <= h_count;
          fb.fb_y <= v_count[Y_W-1:0];
        end

        vga_blank <= ~visible_d;
        vga_hsync <= ~hs_d;
        vga_vsync <= ~vs_d;
        // Memory output is don't-care during blanking; never let it through.
        if (visible_d) {vga_r, vga_g, vga_b} <= fb.fb_rgb;
        else           {vga_r, vga_g, vga_b} <= '0;
        frame_start <= first_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout at full and reduced timing
module tb_vga_scanout;

  typedef struct packed {
    logic        en;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        blank;
    logic        hs_n;
    logic        vs_n;
    logic        pclk;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // inst[0]: full 640x480 timing, latency 1; inst[1]: reduced timing, latency 3
  for (genvar gi = 0; gi < 2; gi++) begin : inst
    localparam bit SMALL = (gi == 1);
    localparam int HV  = SMALL ? 8   : 640;
    localparam int HF  = SMALL ? 2   : 16;
    localparam int HS  = SMALL ? 3   : 96;
    localparam int HB  = SMALL ? 3   : 48;
    localparam int VV  = SMALL ? 4   : 480;
    localparam int VF  = SMALL ? 2   : 10;
    localparam int VS  = 2;
    localparam int VB  = SMALL ? 2   : 33;
    localparam int LAT = SMALL ? 3   : 1;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;

    vga_scanout_if fb_if ();
    logic [7:0] r, g, b;
    logic       hs_n, vs_n, blank, pclk, fs;

    vga_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .FB_LATENCY(LAT)
    ) dut (
      .clk(clk), .reset_n(reset_n), .fb(fb_if),
      .vga_r(r), .vga_g(g), .vga_b(b),
      .vga_hsync(hs_n), .vga_vsync(vs_n), .vga_blank(blank),
      .vga_pixel_clock(pclk), .frame_start(fs)
    );

    // Video memory: answers each request LAT pixel periods later, junk otherwise.
    logic [19:0] hist [LAT];
    logic [23:0] junk;
    initial begin
      logic mph;
      mph = 1'b0;
      junk = SMALL ? 24'h5AC3E1 : 24'bx;
      fb_if.fb_rgb = junk;
      for (int i = 0; i < LAT; i++) hist[i] = '0;
      forever begin
        @(posedge clk);
        if (!reset_n) begin
          mph = 1'b0;
          for (int i = 0; i < LAT; i++) hist[i] = '0;
          fb_if.fb_rgb = junk;
        end else begin
          if (mph) begin
            #1;
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {fb_if.fb_read_en, fb_if.fb_x, fb_if.fb_y};
            if (hist[LAT-1][19]) fb_if.fb_rgb = {hist[LAT-1][16:9], hist[LAT-1][7:0], 8'hA5};
            else                 fb_if.fb_rgb = junk;
          end
          mph = ~mph;
        end
      end
    end

    // Reference: pixel index since reset -> position -> expected outputs.
    obs_t exp_q[$];
    initial begin
      obs_t cur;
      int   k, px, py, jx, jy;
      logic ph, v, jv;
      cur = '0; k = 0; ph = 1'b0;
      forever begin
        @(posedge clk);
        if (!reset_n) begin
          k = 0; ph = 1'b0;
          cur = '0; cur.blank = 1'b1; cur.hs_n = 1'b1; cur.vs_n = 1'b1;
        end else begin
          cur.fs = 1'b0;
          if (ph) begin
            px = k % HT;
            py = (k / HT) % VT;
            v  = (px < HV) && (py < VV);
            cur.en = v;
            if (v) begin cur.x = 10'(px); cur.y = 9'(py); end
            if (k >= LAT) begin
              jx = (k - LAT) % HT;
              jy = ((k - LAT) / HT) % VT;
              jv = (jx < HV) && (jy < VV);
              cur.blank = !jv;
              cur.hs_n  = !(jx >= HV + HF && jx < HV + HF + HS);
              cur.vs_n  = !(jy >= VV + VF && jy < VV + VF + VS);
              cur.rgb   = jv ? {jx[7:0], jy[7:0], 8'hA5} : 24'h0;
              cur.fs    = (jx == 0) && (jy == 0);
            end
            k++;
          end
          ph = ~ph;
          cur.pclk = ph;
        end
        exp_q.push_back(cur);
      end
    end

    // Monitor: per-clk scoreboard compare plus pulse width / period tracking.
    initial begin
      obs_t e;
      int   ncyc, hs_run, vs_run, last_hfall, last_fs;
      logic prev_hs;
      ncyc = 0; hs_run = 0; vs_run = 0; last_hfall = -1; last_fs = -1; prev_hs = 1'b1;
      forever begin
        @(negedge clk);
        ncyc++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("inst%0d_req", gi),
                64'({fb_if.fb_read_en, fb_if.fb_x, fb_if.fb_y}), 64'({e.en, e.x, e.y}));
          check($sformatf("inst%0d_sync", gi),
                64'({blank, hs_n, vs_n, pclk, fs}), 64'({e.blank, e.hs_n, e.vs_n, e.pclk, e.fs}));
          check($sformatf("inst%0d_rgb", gi), 64'({r, g, b}), 64'(e.rgb));
        end
        if (!reset_n) begin
          hs_run = 0; vs_run = 0; last_hfall = -1; last_fs = -1; prev_hs = 1'b1;
        end else begin
          if (!hs_n) hs_run++;
          else if (hs_run != 0) begin
            check($sformatf("inst%0d_hsync_width", gi), 64'(hs_run), 64'(HS * 2));
            hs_run = 0;
          end
          if (prev_hs && !hs_n) begin
            if (last_hfall >= 0)
              check($sformatf("inst%0d_line_period", gi), 64'(ncyc - last_hfall), 64'(HT * 2));
            last_hfall = ncyc;
          end
          prev_hs = hs_n;
          if (!vs_n) vs_run++;
          else if (vs_run != 0) begin
            check($sformatf("inst%0d_vsync_width", gi), 64'(vs_run), 64'(VS * HT * 2));
            vs_run = 0;
          end
          if (fs) begin
            if (last_fs >= 0)
              check($sformatf("inst%0d_frame_period", gi), 64'(ncyc - last_fs), 64'(VT * HT * 2));
            last_fs = ncyc;
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b1;

    // Full timing: pixel 656 requested at clk 2+2*656, on the pins one pixel later.
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (inst[0].hs_n !== 1'b0 && n < 4000);
    check("first_hsync_clk", 64'(n), 64'd1316);

    repeat (2000) @(posedge clk);

    // Mid-frame reset for 3 clk.
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Reduced timing: first vsync line 6 -> pixel 96, latency 3 -> clk 2+2*99.
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (inst[1].vs_n !== 1'b0 && n < 1000);
    check("restart_vsync_clk", 64'(n), 64'd200);

    repeat (1800) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
